// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

    // Word address width of the data memory port.
    localparam int MEM_AW = 10;

    typedef enum logic [2:0] {
        LW  = 3'd0,
        LH  = 3'd1,
        LHU = 3'd2,
        LB  = 3'd3,
        LBU = 3'd4,
        SW  = 3'd5,
        SH  = 3'd6,
        SB  = 3'd7
    } lsu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } lsu_state_t;

    function automatic logic is_load(lsu_op_t op);
        return (op == LW) || (op == LH) || (op == LHU) || (op == LB) || (op == LBU);
    endfunction

    function automatic logic is_subword(lsu_op_t op);
        return (op != LW) && (op != SW);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// CPU request/response and data-memory port bundle for the load/store unit.
// Latency: n/a (wires only).
// Backpressure: req_ready low while a request is in flight.
interface lsu_if
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12
) ();
    logic              req_valid;
    logic              req_ready;
    lsu_op_t           req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    // Load/store unit side.
    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
    );

    // CPU / memory side.
    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/lsu_align.sv
// Big-endian alignment check, sub-word extraction/extension and store merge.
// Latency: purely combinational.
// Backpressure: none.
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_op_t     op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    output logic        misaligned_o,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Offset 0 is the most significant byte/half of the word.
    always_comb begin
        case (off_i)
            2'd0:    byte_v = old_i[31:24];
            2'd1:    byte_v = old_i[23:16];
            2'd2:    byte_v = old_i[15:8];
            default: byte_v = old_i[7:0];
        endcase
        half_v = off_i[1] ? old_i[15:0] : old_i[31:16];
    end

    // Words need both low bits clear, halves need bit 0 clear, bytes always fit.
    always_comb begin
        case (op_i)
            LW, SW:      misaligned_o = (off_i != 2'd0);
            LH, LHU, SH: misaligned_o = off_i[0];
            default:     misaligned_o = 1'b0;
        endcase
    end

    // Right-align the selected lane and sign- or zero-extend it.
    always_comb begin
        case (op_i)
            LW:      load_o = old_i;
            LH:      load_o = {{16{half_v[15]}}, half_v};
            LHU:     load_o = {16'h0000, half_v};
            LB:      load_o = {{24{byte_v[7]}}, byte_v};
            LBU:     load_o = {24'h000000, byte_v};
            default: load_o = 32'h0;
        endcase
    end

    // Replace only the addressed lane of the old word with the store data.
    always_comb begin
        merged_o = old_i;
        case (op_i)
            SW: merged_o = wdata_i;
            SH: begin
                if (off_i[1]) merged_o[15:0]  = wdata_i[15:0];
                else          merged_o[31:16] = wdata_i[15:0];
            end
            SB: begin
                case (off_i)
                    2'd0:    merged_o[31:24] = wdata_i[7:0];
                    2'd1:    merged_o[23:16] = wdata_i[7:0];
                    2'd2:    merged_o[15:8]  = wdata_i[7:0];
                    default: merged_o[7:0]   = wdata_i[7:0];
                endcase
            end
            default: merged_o = old_i;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed MIPS load/store front end to a word-addressed sync-read memory.
// Latency: response 1 (misaligned), 2 (SW), 3 (loads), 4 (SH/SB) cycles after accept.
// Backpressure: req_ready only in IDLE; one request in flight, no pipelining.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic clk,
    input  logic rst_n,
    lsu_if.slave bus
);
    lsu_state_t        state_q, state_d;
    lsu_op_t           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [DATA_W-1:0] result_q;

    lsu_op_t           al_op;
    logic [1:0]        al_off;
    logic              al_mis;
    logic [31:0]       al_load;
    logic [31:0]       al_merged;
    logic              accept;

    assign accept = bus.req_valid && (state_q == ST_IDLE);

    // In IDLE the alignment check looks at the incoming request; afterwards at the latched one.
    assign al_op  = (state_q == ST_IDLE) ? bus.req_op : op_q;
    assign al_off = (state_q == ST_IDLE) ? bus.req_addr[1:0] : addr_q[1:0];

    lsu_align u_align (
        .op_i        (al_op),
        .off_i       (al_off),
        .old_i       (bus.mem_rdata),
        .wdata_i     (wdata_q),
        .misaligned_o(al_mis),
        .load_o      (al_load),
        .merged_o    (al_merged)
    );

    // State register; reset abandons any transaction and drops mem_we at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state sequencing: misaligned skips memory, SW skips the read, RMW adds WRITE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = al_mis ? ST_DONE : ST_ISSUE;
            ST_ISSUE: state_d = (op_q == SW) ? ST_DONE : ST_WAIT;
            ST_WAIT:  state_d = is_load(op_q) ? ST_DONE : ST_WRITE;
            ST_WRITE: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Latch the request on accept; capture the load value or merged word when read data arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= LW;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            op_q     <= bus.req_op;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            err_q    <= al_mis;
            result_q <= '0;
        end else if (state_q == ST_WAIT) begin
            result_q <= is_load(op_q) ? al_load : al_merged;
        end
    end

    // Outputs decoded only from registered state so req_* never reaches mem_* combinationally.
    always_comb begin
        bus.req_ready = (state_q == ST_IDLE);
        bus.rsp_valid = (state_q == ST_DONE);
        bus.rsp_err   = (state_q == ST_DONE) && err_q;
        bus.rsp_rdata = ((state_q == ST_DONE) && is_load(op_q) && !err_q) ? result_q : '0;
        bus.mem_addr  = addr_q[ADDR_W-1:2];
        bus.mem_we    = 1'b0;
        bus.mem_wdata = '0;
        if ((state_q == ST_ISSUE) && (op_q == SW)) begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = wdata_q;
        end else if (state_q == ST_WRITE) begin
            bus.mem_we    = 1'b1;
            bus.mem_wdata = result_q;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench: byte-level memory model predicts every response and memory write.
// Latency: checks each response lands on its exact cycle after accept.
// Backpressure: checks req_ready low for the whole busy window.
module tb_load_store_unit;
    import lsu_pkg::*;

    typedef struct {
        int          acc;
        int          due;
        int          we_cyc;
        logic [31:0] rdata;
        logic        err;
        logic        is_store;
        logic [9:0]  waddr;
        logic [31:0] we_word;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_if #(.ADDR_W(12)) bus ();

    load_store_unit #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Word-addressed memory with one-cycle synchronous read, no read on write cycles.
    logic [31:0] mem [0:1023] = '{default: 32'h0};
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        else            bus.mem_rdata     <= mem[bus.mem_addr];
    end

    // Reference state: a flat byte array, big-endian within each word.
    logic [7:0] shadow [0:4095] = '{default: 8'h0};
    exp_t exp_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    int   last_lat, acc_cyc;
    logic [31:0] last_rdata, last_we_data;
    logic        last_err;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t predict(lsu_op_t op, logic [11:0] a, logic [31:0] wd, int acc);
        exp_t e;
        int size, base, off;
        logic [7:0] b [4];
        logic [31:0] v;
        size = (op == LW || op == SW) ? 4 : (op == LH || op == LHU || op == SH) ? 2 : 1;
        base = int'(a) & ~3;
        off  = int'(a) % 4;
        e.acc      = acc;
        e.is_store = (op == SW || op == SH || op == SB);
        e.err      = (int'(a) % size) != 0;
        e.due      = acc + (e.err ? 1 : (op == SW) ? 2 : e.is_store ? 4 : 3);
        e.we_cyc   = (!e.err && e.is_store) ? acc + ((op == SW) ? 1 : 3) : -1;
        e.waddr    = a[11:2];
        v = 32'h0;
        if (!e.err && !e.is_store) begin
            for (int i = 0; i < size; i++) v = (v << 8) | 32'(shadow[int'(a) + i]);
            if ((op == LH || op == LB) && v[8*size-1])
                for (int i = size; i < 4; i++) v = v | (32'hFF << (8 * i));
        end
        e.rdata = v;
        for (int i = 0; i < 4; i++) b[i] = shadow[base + i];
        for (int i = 0; i < size; i++) b[off + i] = wd[8*(size-1-i) +: 8];
        e.we_word = {b[0], b[1], b[2], b[3]};
        return e;
    endfunction

    // Every cycle out of reset: handshake, memory write strobe and response vs. the model.
    always @(negedge clk) begin
        bit busy, exp_we;
        exp_t e;
        cyc++;
        if (rst_n) begin
            busy   = exp_q.size() > 0;
            exp_we = busy && (exp_q[0].we_cyc == cyc);
            chk("req_ready", 32'(bus.req_ready), 32'(!busy));
            chk("mem_we", 32'(bus.mem_we), 32'(exp_we));
            if (exp_we) begin
                chk("mem_addr", 32'(bus.mem_addr), 32'(exp_q[0].waddr));
                chk("mem_wdata", bus.mem_wdata, exp_q[0].we_word);
                last_we_data = bus.mem_wdata;
            end
            if (busy && exp_q[0].due == cyc) begin
                e = exp_q.pop_front();
                chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
                chk("rsp_rdata", bus.rsp_rdata, e.rdata);
                chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                last_rdata = bus.rsp_rdata;
                last_err   = bus.rsp_err;
                last_lat   = cyc - e.acc;
                if (e.is_store && !e.err)
                    for (int i = 0; i < 4; i++)
                        shadow[int'({e.waddr, 2'b00}) + i] = e.we_word[8*(3-i) +: 8];
            end else begin
                chk("rsp_valid_idle", 32'(bus.rsp_valid), 32'd0);
            end
        end
    end

    // Called at negedge+1; returns one cycle after the accepting edge with req_valid still high.
    task automatic send(lsu_op_t op, logic [11:0] a, logic [31:0] wd);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        for (int k = 0; k < 30; k++) begin
            if (bus.req_ready) begin
                exp_q.push_back(predict(op, a, wd, cyc));
                acc_cyc = cyc;
                @(negedge clk); #1;
                return;
            end
            @(negedge clk); #1;
        end
        chk("accept_timeout", 32'd0, 32'd1);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        bus.req_valid = 1'b0;
        for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
            @(negedge clk); #1;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        int a1, a2;
        bus.req_valid = 1'b0;
        bus.req_op    = LW;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;

        // SW then LW round trip.
        send(SW, 12'h010, 32'h12345678); drain();
        chk("sw_latency", 32'(last_lat), 32'd2);
        chk("sw_mem_word4", mem[4], 32'h12345678);
        send(LW, 12'h010, 32'h0); drain();
        chk("lw_data", last_rdata, 32'h12345678);
        chk("lw_latency", 32'(last_lat), 32'd3);

        // Sub-word loads from 0x8899AABB.
        send(SW, 12'h010, 32'h8899AABB); drain();
        send(LB, 12'h011, 32'h0); drain();
        chk("lb_011", last_rdata, 32'hFFFFFF99);
        send(LBU, 12'h011, 32'h0); drain();
        chk("lbu_011", last_rdata, 32'h00000099);
        send(LH, 12'h012, 32'h0); drain();
        chk("lh_012", last_rdata, 32'hFFFFAABB);
        send(LHU, 12'h010, 32'h0); drain();
        chk("lhu_010", last_rdata, 32'h00008899);
        send(LBU, 12'h013, 32'h0); drain();
        chk("lbu_013", last_rdata, 32'h000000BB);

        // Read-modify-write stores.
        send(SB, 12'h013, 32'h000000CC); drain();
        chk("sb_wdata", last_we_data, 32'h8899AACC);
        chk("sb_latency", 32'(last_lat), 32'd4);
        send(SH, 12'h010, 32'h00001122); drain();
        send(LW, 12'h010, 32'h0); drain();
        chk("sh_readback", last_rdata, 32'h1122AACC);

        // Misaligned requests never reach memory.
        send(LW, 12'h006, 32'h0); drain();
        chk("lw_mis_err", 32'(last_err), 32'd1);
        chk("lw_mis_lat", 32'(last_lat), 32'd1);
        send(SH, 12'h005, 32'hFFFFFFFF); drain();
        chk("sh_mis_err", 32'(last_err), 32'd1);
        chk("sh_mis_rdata", last_rdata, 32'd0);
        chk("sh_mis_mem1", mem[1], 32'd0);

        // Reset during WAIT of an SB: no write, no response.
        send(SB, 12'h013, 32'h000000DD);
        bus.req_valid = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("mid_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("mid_rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        exp_q.delete();
        @(negedge clk); #1 rst_n = 1'b1;
        @(negedge clk); #1;
        chk("mid_rst_word4", mem[4], 32'h1122AACC);
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        send(LW, 12'h010, 32'h0); drain();
        chk("post_rst_lw", last_rdata, 32'h1122AACC);

        // Back-to-back with req_valid held high.
        send(LW, 12'h010, 32'h0); a1 = acc_cyc;
        send(LW, 12'h000, 32'h0); a2 = acc_cyc;
        drain();
        chk("b2b_accept_gap", 32'(a2 - a1), 32'd4);
        chk("b2b_second_data", last_rdata, 32'h0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
